// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controllers: phase codes, lamp codes, default timer width.
package traffic_pkg;

  localparam int DEF_TIME_W = 7;

  typedef enum logic [1:0] {
    PH_IDLE   = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10,
    PH_ALLRED = 2'b11
  } phase_e;

  typedef enum logic [1:0] {
    LT_RED    = 2'b00,
    LT_YELLOW = 2'b01,
    LT_GREEN  = 2'b10,
    LT_FLASH  = 2'b11
  } light_e;

endpackage

// File: rtl/phase_timer.sv
// Phase countdown: loads a duration, counts down to zero, and flags the last cycle of the phase.
module phase_timer
  import traffic_pkg::*;
#(
  parameter int TIME_W = DEF_TIME_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [TIME_W-1:0] load_val_i,
  output logic [TIME_W-1:0] count_o,
  output logic              last_o
);

  logic [TIME_W-1:0] count_q, count_d;
  logic              last_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - TIME_W'(1);
    end
  end

  // last is registered from the next count so it lines up with count_o == 1
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      last_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      last_q  <= (count_d == TIME_W'(1));
    end
  end

  assign count_o = count_q;
  assign last_o  = last_q;

endmodule

// File: rtl/multi_lane_auto_ctrl.sv
// Round-robin automatic-mode controller for NUM_LANES approaches (GREEN/YELLOW/ALLRED).
// Define DEMAND_SKIP_EN to pick the next green lane by rotating priority over demand_i.
module multi_lane_auto_ctrl
  import traffic_pkg::*;
#(
  parameter  int NUM_LANES = 4,
  parameter  int TIME_W    = DEF_TIME_W,
  localparam int LANE_W    = $clog2(NUM_LANES)
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   enable_i,
  input  logic [TIME_W-1:0]      green_time_i,
  input  logic [TIME_W-1:0]      yellow_time_i,
  input  logic [TIME_W-1:0]      allred_time_i,
  input  logic [NUM_LANES-1:0]   demand_i,
  output logic [2*NUM_LANES-1:0] lights_o,
  output logic [LANE_W-1:0]      active_lane_o,
  output logic [1:0]             phase_o,
  output logic [TIME_W-1:0]      time_left_o,
  output logic                   phase_done_o,
  output logic                   cycle_start_o
);

  phase_e                 phase_q, phase_d;
  logic [LANE_W-1:0]      lane_q, lane_d;
  logic [LANE_W-1:0]      target_q, target_d;
  logic [2*NUM_LANES-1:0] lights_q, lights_d;
  logic                   cycleStart_q, cycleStart_d;
  logic                   timerClear, timerLoad, timerLast;
  logic [TIME_W-1:0]      timerVal;
  logic [LANE_W:0]        pick;

  function automatic logic [TIME_W-1:0] atLeastOne(input logic [TIME_W-1:0] d);
    return (d == '0) ? TIME_W'(1) : d;
  endfunction

  // Returns {valid, lane}; valid=0 means no other lane wants service
  function automatic logic [LANE_W:0] pickNext(input logic [LANE_W-1:0] cur);
    logic [LANE_W:0] res;
    res = {1'b1, LANE_W'((int'(cur) + 1) % NUM_LANES)};
`ifdef DEMAND_SKIP_EN
    res = '0;
    for (int k = NUM_LANES - 1; k >= 1; k--) begin
      logic [LANE_W-1:0] idx;
      idx = LANE_W'((int'(cur) + k) % NUM_LANES);
      if (demand_i[idx]) res = {1'b1, idx};
    end
`endif
    return res;
  endfunction

`ifndef DEMAND_SKIP_EN
  logic unusedDemand;
  assign unusedDemand = ^demand_i;
`endif

  always_comb begin
    phase_d      = phase_q;
    lane_d       = lane_q;
    target_d     = target_q;
    cycleStart_d = 1'b0;
    timerClear   = 1'b0;
    timerLoad    = 1'b0;
    timerVal     = '0;
    pick         = pickNext(lane_q);
    if (!enable_i) begin
      phase_d    = PH_IDLE;
      lane_d     = '0;
      timerClear = 1'b1;
    end else begin
      case (phase_q)
        PH_IDLE: begin
          phase_d      = PH_GREEN;
          lane_d       = '0;
          timerLoad    = 1'b1;
          timerVal     = atLeastOne(green_time_i);
          cycleStart_d = 1'b1;
        end
        PH_GREEN: if (timerLast) begin
          timerLoad = 1'b1;
          if (pick[LANE_W]) begin
            phase_d  = PH_YELLOW;
            target_d = pick[LANE_W-1:0];
            timerVal = atLeastOne(yellow_time_i);
          end else begin
            timerVal = atLeastOne(green_time_i);
          end
        end
        PH_YELLOW: if (timerLast) begin
          timerLoad = 1'b1;
          if (allred_time_i != '0) begin
            phase_d  = PH_ALLRED;
            timerVal = allred_time_i;
          end else begin
            phase_d      = PH_GREEN;
            lane_d       = target_q;
            timerVal     = atLeastOne(green_time_i);
            cycleStart_d = (target_q == '0);
          end
        end
        PH_ALLRED: if (timerLast) begin
          timerLoad    = 1'b1;
          phase_d      = PH_GREEN;
          lane_d       = target_q;
          timerVal     = atLeastOne(green_time_i);
          cycleStart_d = (target_q == '0);
        end
        default: phase_d = PH_IDLE;
      endcase
    end

    lights_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      lights_d[2*i +: 2] = LT_RED;
      if (phase_d == PH_IDLE) begin
        lights_d[2*i +: 2] = LT_FLASH;
      end else if (LANE_W'(i) == lane_d) begin
        if (phase_d == PH_GREEN)  lights_d[2*i +: 2] = LT_GREEN;
        if (phase_d == PH_YELLOW) lights_d[2*i +: 2] = LT_YELLOW;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      phase_q      <= PH_IDLE;
      lane_q       <= '0;
      target_q     <= '0;
      lights_q     <= '0;
      cycleStart_q <= 1'b0;
    end else begin
      phase_q      <= phase_d;
      lane_q       <= lane_d;
      target_q     <= target_d;
      lights_q     <= lights_d;
      cycleStart_q <= cycleStart_d;
    end
  end

  phase_timer #(.TIME_W(TIME_W)) uTimer (
    .clk_i      (clk_i),
    .rst_ni     (reset_ni),
    .clear_i    (timerClear),
    .load_i     (timerLoad),
    .load_val_i (timerVal),
    .count_o    (time_left_o),
    .last_o     (timerLast)
  );

  assign lights_o      = lights_q;
  assign active_lane_o = lane_q;
  assign phase_o       = phase_q;
  assign phase_done_o  = timerLast;
  assign cycle_start_o = cycleStart_q;

endmodule
